// File: rtl/spectrum_pkg.sv
// Shared defaults and state encoding for the spectrum frame fetch block.
package spectrum_pkg;

    localparam int unsigned DEF_N_BINS = 256;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/spectrum_frame_fetch.sv
// Arbitrates the spectrum magnitude RAM between the FFT writer and a per-frame
// snapshot copy of all bins into the display line buffer.
module spectrum_frame_fetch
    import spectrum_pkg::*;
#(
    parameter int unsigned N_BINS = DEF_N_BINS,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              frame,
    input  logic              fetch_en,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              lb_we,
    output logic [ADDR_W-1:0] lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] bin_cnt;

    assign lb_data = ram_rdata;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state      <= IDLE;
            bin_cnt    <= '0;
            wr_ack     <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            lb_we      <= 1'b0;
            lb_addr    <= '0;
            fetch_busy <= 1'b0;
            fetch_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Read data arrives one cycle after the address, so the line-buffer
            // strobe and address trail the RAM read by one cycle.
            lb_we      <= (state == FETCH);
            lb_addr    <= ram_addr;
            fetch_done <= (state == FETCH) && (bin_cnt == LAST_BIN);

            if (frame && (state != IDLE))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame && fetch_en) begin
                        state      <= FETCH;
                        fetch_busy <= 1'b1;
                        bin_cnt    <= '0;
                        ram_en     <= 1'b1;
                        ram_we     <= 1'b0;
                        ram_addr   <= '0;
                        wr_ack     <= 1'b0;
                    end else if (wr_req && !wr_ack) begin
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= wr_addr;
                        ram_wdata <= wr_data;
                        wr_ack    <= 1'b1;
                    end else begin
                        ram_en <= 1'b0;
                        ram_we <= 1'b0;
                        wr_ack <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bin_cnt == LAST_BIN) begin
                        state   <= DRAIN;
                        bin_cnt <= '0;
                        ram_en  <= 1'b0;
                    end else begin
                        bin_cnt  <= bin_cnt + 1'b1;
                        ram_addr <= bin_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state      <= IDLE;
                    fetch_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    fetch_busy <= 1'b0;
                    ram_en     <= 1'b0;
                    ram_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spectrum_frame_fetch.sv
// Directed and randomized checks of spectrum_frame_fetch against a RAM model
// and a shadow copy of the magnitudes the writer has stored.
module tb_spectrum_frame_fetch;

    localparam int N  = 8;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_pix;
    logic          frame;
    logic          fetch_en;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          lb_we;
    logic [AW-1:0] lb_addr;
    logic [DW-1:0] lb_data;
    logic          fetch_busy;
    logic          fetch_done;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;
    logic          ovr_exp = 1'b0;
    logic [DW-1:0] shadow [N];
    logic [DW-1:0] mem [2**AW];

    always #5 clk = ~clk;

    spectrum_frame_fetch #(.N_BINS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_pix(clk), .rst_pix(rst_pix), .frame(frame), .fetch_en(fetch_en),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done), .overrun(overrun)
    );

    // Single-port synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_pix && ram_en && !ram_we)
            chk("rd_addr_range", 32'(ram_addr < AW'(N)), 1);
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_wr_ack"}, wr_ack, 0);
        chk({tag, "_lb_we"}, lb_we, 0);
        chk({tag, "_lb_addr"}, lb_addr, 0);
        chk({tag, "_fetch_busy"}, fetch_busy, 0);
        chk({tag, "_fetch_done"}, fetch_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 0;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_ack) begin
                got = 1;
                chk("wr_ram_en", ram_en, 1);
                chk("wr_ram_we", ram_we, 1);
                chk("wr_ram_addr", ram_addr, a);
                chk("wr_ram_wdata", ram_wdata, d);
                break;
            end
        end
        wr_req = 1'b0;
        chk("wr_ack_seen", got, 1);
        shadow[a] = d;
        tick();
        chk("idle_ram_en", ram_en, 0);
        chk("idle_busy", fetch_busy, 0);
    endtask

    // Frame at cycle t; optional second frame at t+frame2_at; optional write
    // requested together with the frame, expected to be acked at t+N+3.
    task automatic snapshot(input int frame2_at, input bit pend,
                            input logic [AW-1:0] pa, input logic [DW-1:0] pd);
        logic ovr_before = ovr_exp;
        frame    = 1'b1;
        fetch_en = 1'b1;
        if (pend) begin
            wr_req  = 1'b1;
            wr_addr = pa;
            wr_data = pd;
        end
        for (int k = 1; k <= N + 2; k++) begin
            tick();
            frame = (k == frame2_at);
            chk("snap_ram_en", ram_en, 32'(k <= N));
            if (k <= N) begin
                chk("snap_ram_addr", ram_addr, k - 1);
                chk("snap_ram_we", ram_we, 0);
            end
            chk("snap_lb_we", lb_we, 32'(k >= 2 && k <= N + 1));
            if (k >= 2 && k <= N + 1) begin
                chk("snap_lb_addr", lb_addr, k - 2);
                chk("snap_lb_data", lb_data, shadow[k-2]);
            end
            chk("snap_done", fetch_done, 32'(k == N + 1));
            chk("snap_busy", fetch_busy, 32'(k <= N + 1));
            chk("snap_no_ack", wr_ack, 0);
            chk("snap_overrun", overrun, 32'(ovr_before || (frame2_at != 0 && k > frame2_at)));
        end
        frame = 1'b0;
        if (frame2_at != 0) ovr_exp = 1'b1;
        if (pend) begin
            tick();
            chk("cont_ack", wr_ack, 1);
            chk("cont_we", ram_we, 1);
            chk("cont_addr", ram_addr, pa);
            chk("cont_wdata", ram_wdata, pd);
            wr_req = 1'b0;
            shadow[pa] = pd;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_pix  = 1'b1;
        frame    = 1'b0;
        fetch_en = 1'b1;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        for (int i = 0; i < N; i++) shadow[i] = '0;

        tick();
        tick();
        check_all_zero("rst");
        rst_pix = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("post_rst");
        end

        // Idle write, request held through the ack cycle.
        wr_req  = 1'b1;
        wr_addr = 4'd5;
        wr_data = 16'h1234;
        tick();
        chk("w1_ack", wr_ack, 1);
        chk("w1_en", ram_en, 1);
        chk("w1_we", ram_we, 1);
        chk("w1_addr", ram_addr, 5);
        chk("w1_wdata", ram_wdata, 16'h1234);
        tick();
        wr_req = 1'b0;
        chk("w1_no_second_ack", wr_ack, 0);
        chk("w1_no_second_en", ram_en, 0);
        shadow[5] = 16'h1234;
        tick();

        for (int i = 0; i < N; i++) do_write(AW'(i), DW'(i * 3));
        snapshot(0, 0, '0, '0);
        snapshot(0, 1, 4'd2, 16'hBEEF);
        snapshot(4, 0, '0, '0);
        chk("ovr_sticky", overrun, 1);

        // Frozen display: frame ignored, overrun untouched.
        fetch_en = 1'b0;
        frame    = 1'b1;
        tick();
        frame = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("freeze_ram_en", ram_en, 0);
            chk("freeze_busy", fetch_busy, 0);
            chk("freeze_ovr", overrun, ovr_exp);
            tick();
        end
        fetch_en = 1'b1;

        // Reset in the middle of a snapshot.
        frame = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            frame = 1'b0;
        end
        chk("midrst_busy_before", fetch_busy, 1);
        rst_pix = 1'b1;
        tick();
        check_all_zero("midrst");
        rst_pix = 1'b0;
        ovr_exp = 1'b0;
        tick();
        chk("midrst_no_lb_we", lb_we, 0);
        chk("midrst_idle", fetch_busy, 0);
        snapshot(0, 0, '0, '0);

        for (int it = 0; it < 30; it++) begin
            int r = $urandom_range(0, 3);
            case (r)
                0, 1: do_write(AW'($urandom_range(0, N - 1)), DW'($urandom));
                2: snapshot(($urandom_range(0, 1) == 1) ? $urandom_range(1, N + 1) : 0, 0, '0, '0);
                default: snapshot(0, 1, AW'($urandom_range(0, N - 1)), DW'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spectrum_frame_fetch.md
Name: spectrum_frame_fetch

Overview:
- Arbitrates the single-port spectrum magnitude RAM between two users: the FFT magnitude writer and the display path.
- On each frame pulse from the display timing generator, takes the RAM and snapshots all N_BINS magnitudes into the display line buffer, so the bar graph never tears mid-frame.
- Outside a snapshot the writer owns the RAM.
- Lives in the clk_pix domain, between the timing generator and the spectrum renderer.

Parameters:
N_BINS, 256, number of spectrum bins copied per snapshot (>=2)
ADDR_W, 8, bin address width; must satisfy 2**ADDR_W >= N_BINS
DATA_W, 16, magnitude word width

Ports:
clk_pix  in  1  pixel clock; single clock domain
rst_pix  in  1  synchronous, active-high reset
frame  in  1  one-cycle frame-start pulse from timing generator
fetch_en  in  1  1 = snapshot on frame; 0 = ignore frames (freeze display)
wr_req  in  1  writer request; held with stable wr_addr/wr_data until wr_ack
wr_addr  in  ADDR_W  writer bin address
wr_data  in  DATA_W  writer magnitude
wr_ack  out  1  one-cycle pulse: write performed this cycle
ram_en  out  1  RAM enable (registered)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en with ram_we=0
lb_we  out  1  line-buffer write strobe (registered)
lb_addr  out  ADDR_W  line-buffer address (registered)
lb_data  out  DATA_W  equals ram_rdata (combinational pass-through)
fetch_busy  out  1  high in FETCH and DRAIN
fetch_done  out  1  one-cycle pulse at the final lb_we
overrun  out  1  sticky: a frame arrived while not IDLE; cleared only by reset

Behaviour:
- Reset: state IDLE, bin counter 0. All registered outputs and flags go to 0: ram_en, ram_we, ram_addr, ram_wdata, wr_ack, lb_we, lb_addr, fetch_busy, fetch_done, overrun.
- Reset mid-fetch aborts the snapshot immediately. There is no lb_we in the cycle after reset.
- States: IDLE, FETCH, DRAIN.
- IDLE, priority order:
  - frame&fetch_en -> FETCH. Frame beats a simultaneous wr_req; the write waits.
  - Else wr_req and wr_ack currently 0 -> next cycle ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1.
  - No new write is accepted in the cycle wr_ack=1, so throughput is at most one write per 2 cycles.
- frame sampled at cycle t in IDLE (and not in wr_ack cycle, or in it; the pending write still completes at t, being single-cycle):
  - t+1..t+N_BINS: FETCH. ram_en=1, ram_we=0, ram_addr=0,1,...,N_BINS-1, one per cycle.
  - t+2..t+N_BINS+1: lb_we=1, lb_addr=0..N_BINS-1, lb_data=ram_rdata. Latency from read address to lb_we is 1 cycle.
  - t+N_BINS+1: DRAIN. fetch_done=1 (with the last lb_we), ram_en=0.
  - t+N_BINS+2: IDLE. A wr_req held through the snapshot gets wr_ack at t+N_BINS+3 at the earliest.
- fetch_busy=1 from t+1 to t+N_BINS+1 inclusive.
- frame while in FETCH or DRAIN: ignored, no restart, overrun<=1.
- frame with fetch_en=0: ignored, no overrun.
- Bin counter wraps to 0 on the FETCH->DRAIN transition. No address ever exceeds N_BINS-1.
- wr_req is never dropped. It stays pending through FETCH/DRAIN with no ack.
- Integration constraint: N_BINS+2 must not exceed the pixel clocks between frame and first active pixel. The block does not enforce this.

Decomposition:
- Shared package spectrum_pkg: N_BINS, ADDR_W, DATA_W defaults; state enumeration (IDLE=0, FETCH=1, DRAIN=2, 2-bit encoding).
- No sub-module. The bin counter and FSM fit in one module of roughly 150-200 lines.

Test Plan:
- Reset: hold rst_pix 2 cycles -> every output 0. Release with no requests -> outputs stay 0.
- Idle write: wr_req=1, wr_addr=5, wr_data=0x1234 at cycle t -> at t+1 ram_we=1, ram_addr=5, ram_wdata=0x1234, wr_ack=1; no second write at t+1.
- Snapshot, N_BINS=8, RAM preloaded with value=addr*3: frame at t -> ram_addr 0..7 at t+1..t+8; lb_we t+2..t+9 with lb_data 0,3,...,21; fetch_done only at t+9; fetch_busy t+1..t+9.
- Contention: frame and wr_req together at t -> no wr_ack through t+9; wr_ack at t+11 with correct address/data.
- Overrun/freeze: second frame at t+4 -> overrun=1 stays high, snapshot unchanged. frame with fetch_en=0 -> no ram_en, overrun unchanged.
- Reset mid-fetch: rst_pix at t+4 -> at t+5 all outputs 0, state IDLE. Next frame starts a full snapshot from address 0.
